pipe_idex_hazard: RTL and testbench

ID-to-EX pipeline register with load-use hazard detection and a stall FSM. It captures the forwarded decode operands (op*_data_FWD_ID) plus control, and drives the *_IDtoEX / load_true_EX signals that the EX-stage forwarding logic consumes. On a load-use dependency it stalls IF/ID for LOAD_LAT cycles and injects bubbles into EX.

---
 rtl/pipe_idex_hazard.sv | 202 ++++++++++++++++++++
 tb/tb_pipe_idex_hazard.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_idex_hazard.sv
//-----------------------------------------------------------------------------
// pipe_idex_hazard
//
// ID-to-EX pipeline register with load-use hazard detection and a small
// stall FSM. The register captures the forwarded decode operands and the
// decode control fields, and presents them to the EX stage (*_IDtoEX,
// load_true_EX). When the instruction in decode reads the destination of a
// load sitting in EX, IF/ID is held (stall_IF) for LOAD_LAT cycles and a
// bubble (all-zero payload) is injected into EX for each of those cycles.
//
// Parameters
//   NUM_DOMAINS : 8-bit RNS residue lanes per op1/op2 operand
//   LOAD_LAT    : stall cycles per load-use hazard, 1..7
//   OPC_W       : opcode width
//
// Ports
//   clk, rst_n                 : rising-edge clock, async active-low reset
//   en                         : global advance; 0 freezes all state
//   flush                      : kills the instruction entering EX
//   op*_addr_IFID              : decode source addresses (op3 is 3 bits)
//   op*_data_FWD_ID            : forwarded decode operands
//   opcode_IFID, dest_addr_IFID: decode opcode and destination
//   reg_wr_en_IFID             : decode instruction writes a register
//   load_true_IFID             : decode instruction is a load
//   reg_rd_en_IFID             : decode source addresses are meaningful
//   op*_addr_IDtoEX, op*_data_IDtoEX, opcode_IDtoEX, dest_addr_IDtoEX,
//   reg_wr_en_IDtoEX, load_true_EX : registered EX-stage payload
//   stall_IF                   : combinational hold for PC and IF/ID
//   stall_cycles               : saturating count of stalled cycles
//-----------------------------------------------------------------------------
module pipe_idex_hazard #(
    parameter int NUM_DOMAINS = 1,
    parameter int LOAD_LAT    = 1,
    parameter int OPC_W       = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     flush,

    input  logic [3:0]               op1_addr_IFID,
    input  logic [3:0]               op2_addr_IFID,
    input  logic [2:0]               op3_addr_IFID,
    input  logic [NUM_DOMAINS*8-1:0] op1_data_FWD_ID,
    input  logic [NUM_DOMAINS*8-1:0] op2_data_FWD_ID,
    input  logic [7:0]               op3_data_FWD_ID,
    input  logic [OPC_W-1:0]         opcode_IFID,
    input  logic [3:0]               dest_addr_IFID,
    input  logic                     reg_wr_en_IFID,
    input  logic                     load_true_IFID,
    input  logic                     reg_rd_en_IFID,

    output logic [3:0]               op1_addr_IDtoEX,
    output logic [3:0]               op2_addr_IDtoEX,
    output logic [2:0]               op3_addr_IDtoEX,
    output logic [NUM_DOMAINS*8-1:0] op1_data_IDtoEX,
    output logic [NUM_DOMAINS*8-1:0] op2_data_IDtoEX,
    output logic [7:0]               op3_data_IDtoEX,
    output logic [OPC_W-1:0]         opcode_IDtoEX,
    output logic [3:0]               dest_addr_IDtoEX,
    output logic                     reg_wr_en_IDtoEX,
    output logic                     load_true_EX,
    output logic                     stall_IF,
    output logic [15:0]              stall_cycles
);

    localparam int DW = NUM_DOMAINS * 8;

    // Remaining stall count after the hazard cycle itself.
    localparam logic [2:0] STALL_RELOAD = 3'(LOAD_LAT - 1);

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    // Everything the EX stage sees; an all-zero value is a bubble.
    typedef struct packed {
        logic [3:0]       op1_addr;
        logic [3:0]       op2_addr;
        logic [2:0]       op3_addr;
        logic [DW-1:0]    op1_data;
        logic [DW-1:0]    op2_data;
        logic [7:0]       op3_data;
        logic [OPC_W-1:0] opcode;
        logic [3:0]       dest_addr;
        logic             reg_wr_en;
        logic             load_true;
    } idex_t;

    state_t      state, state_nxt;
    logic [2:0]  cnt, cnt_nxt;
    idex_t       ex_q, ex_nxt, id_in;
    logic [15:0] stall_cnt_q;
    logic        src_match;
    logic        hazard;

    assign id_in = '{
        op1_addr : op1_addr_IFID,
        op2_addr : op2_addr_IFID,
        op3_addr : op3_addr_IFID,
        op1_data : op1_data_FWD_ID,
        op2_data : op2_data_FWD_ID,
        op3_data : op3_data_FWD_ID,
        opcode   : opcode_IFID,
        dest_addr: dest_addr_IFID,
        reg_wr_en: reg_wr_en_IFID,
        load_true: load_true_IFID
    };

    //-------------------------------------------------------------------------
    // Hazard detection. Register 0 is an ordinary register here, so a match
    // on address 0 is a genuine dependency.
    //-------------------------------------------------------------------------
    assign src_match = (op1_addr_IFID == ex_q.dest_addr) ||
                       (op2_addr_IFID == ex_q.dest_addr) ||
                       ({1'b0, op3_addr_IFID} == ex_q.dest_addr);

    assign hazard = (state == RUN) && ex_q.load_true && ex_q.reg_wr_en &&
                    reg_rd_en_IFID && src_match;

    // A flush discards the dependent instruction anyway, so it never stalls.
    assign stall_IF = !flush && (hazard || (state == STALL));

    //-------------------------------------------------------------------------
    // Stall FSM next state. With LOAD_LAT == 1 the hazard cycle alone covers
    // the latency and the FSM never leaves RUN.
    //-------------------------------------------------------------------------
    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (flush) begin
            state_nxt = RUN;
            cnt_nxt   = '0;
        end else begin
            case (state)
                RUN: begin
                    if (hazard && (LOAD_LAT > 1)) begin
                        state_nxt = STALL;
                        cnt_nxt   = STALL_RELOAD;
                    end
                end
                STALL: begin
                    if (cnt <= 3'd1) begin
                        state_nxt = RUN;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt - 3'd1;
                    end
                end
                default: begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Payload: a bubble on flush or stall, otherwise the decode instruction.
    always_comb begin
        ex_nxt = id_in;
        if (flush || stall_IF) begin
            ex_nxt = '0;
        end
    end

    //-------------------------------------------------------------------------
    // State registers. en=0 freezes everything, including the stall counter.
    //-------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            cnt         <= '0;
            ex_q        <= '0;
            stall_cnt_q <= '0;
        end else if (en) begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            ex_q  <= ex_nxt;
            if (stall_IF && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign op1_addr_IDtoEX  = ex_q.op1_addr;
    assign op2_addr_IDtoEX  = ex_q.op2_addr;
    assign op3_addr_IDtoEX  = ex_q.op3_addr;
    assign op1_data_IDtoEX  = ex_q.op1_data;
    assign op2_data_IDtoEX  = ex_q.op2_data;
    assign op3_data_IDtoEX  = ex_q.op3_data;
    assign opcode_IDtoEX    = ex_q.opcode;
    assign dest_addr_IDtoEX = ex_q.dest_addr;
    assign reg_wr_en_IDtoEX = ex_q.reg_wr_en;
    assign load_true_EX     = ex_q.load_true;
    assign stall_cycles     = stall_cnt_q;

endmodule

// File: tb/tb_pipe_idex_hazard.sv
//-----------------------------------------------------------------------------
// tb_pipe_idex_hazard
//
// Two instances share one stimulus stream: u_lat1 (LOAD_LAT=1) and u_lat3
// (LOAD_LAT=3), both with two RNS lanes. Each has its own reference model
// that tracks the EX payload, the number of stall cycles still owed, and the
// stall counter. Directed scenarios come first, then randomized traffic.
//-----------------------------------------------------------------------------
module tb_pipe_idex_hazard;

    localparam int ND = 2;
    localparam int DW = ND * 8;

    typedef struct packed {
        logic [3:0]    a1;
        logic [3:0]    a2;
        logic [2:0]    a3;
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
        logic [7:0]    d3;
        logic [4:0]    opc;
        logic [3:0]    dest;
        logic          wr;
        logic          ld;
    } ex_t;

    logic clk, rst_n, en, flush;
    logic [3:0]    a1, a2, dest;
    logic [2:0]    a3;
    logic [DW-1:0] d1, d2;
    logic [7:0]    d3;
    logic [4:0]    opc;
    logic          wr, ld, rd;

    // DUT outputs
    logic [3:0]    x1_a1, x1_a2, x1_dest, x3_a1, x3_a2, x3_dest;
    logic [2:0]    x1_a3, x3_a3;
    logic [DW-1:0] x1_d1, x1_d2, x3_d1, x3_d2;
    logic [7:0]    x1_d3, x3_d3;
    logic [4:0]    x1_opc, x3_opc;
    logic          x1_wr, x1_ld, x1_stall, x3_wr, x3_ld, x3_stall;
    logic [15:0]   x1_sc, x3_sc;

    pipe_idex_hazard #(.NUM_DOMAINS(ND), .LOAD_LAT(1), .OPC_W(5)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
        .op1_addr_IFID(a1), .op2_addr_IFID(a2), .op3_addr_IFID(a3),
        .op1_data_FWD_ID(d1), .op2_data_FWD_ID(d2), .op3_data_FWD_ID(d3),
        .opcode_IFID(opc), .dest_addr_IFID(dest), .reg_wr_en_IFID(wr),
        .load_true_IFID(ld), .reg_rd_en_IFID(rd),
        .op1_addr_IDtoEX(x1_a1), .op2_addr_IDtoEX(x1_a2), .op3_addr_IDtoEX(x1_a3),
        .op1_data_IDtoEX(x1_d1), .op2_data_IDtoEX(x1_d2), .op3_data_IDtoEX(x1_d3),
        .opcode_IDtoEX(x1_opc), .dest_addr_IDtoEX(x1_dest),
        .reg_wr_en_IDtoEX(x1_wr), .load_true_EX(x1_ld),
        .stall_IF(x1_stall), .stall_cycles(x1_sc)
    );

    pipe_idex_hazard #(.NUM_DOMAINS(ND), .LOAD_LAT(3), .OPC_W(5)) u_lat3 (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
        .op1_addr_IFID(a1), .op2_addr_IFID(a2), .op3_addr_IFID(a3),
        .op1_data_FWD_ID(d1), .op2_data_FWD_ID(d2), .op3_data_FWD_ID(d3),
        .opcode_IFID(opc), .dest_addr_IFID(dest), .reg_wr_en_IFID(wr),
        .load_true_IFID(ld), .reg_rd_en_IFID(rd),
        .op1_addr_IDtoEX(x3_a1), .op2_addr_IDtoEX(x3_a2), .op3_addr_IDtoEX(x3_a3),
        .op1_data_IDtoEX(x3_d1), .op2_data_IDtoEX(x3_d2), .op3_data_IDtoEX(x3_d3),
        .opcode_IDtoEX(x3_opc), .dest_addr_IDtoEX(x3_dest),
        .reg_wr_en_IDtoEX(x3_wr), .load_true_EX(x3_ld),
        .stall_IF(x3_stall), .stall_cycles(x3_sc)
    );

    ex_t got_ex [2];
    assign got_ex[0] = {x1_a1, x1_a2, x1_a3, x1_d1, x1_d2, x1_d3, x1_opc, x1_dest, x1_wr, x1_ld};
    assign got_ex[1] = {x3_a1, x3_a2, x3_a3, x3_d1, x3_d2, x3_d3, x3_opc, x3_dest, x3_wr, x3_ld};

    // Reference model state, one entry per instance.
    int  lat [2] = '{1, 3};
    ex_t m_ex [2];
    int  m_owed [2];   // stall cycles still owed after the current one
    int  m_sc [2];

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_ex[d]   = '0;
            m_owed[d] = 0;
            m_sc[d]   = 0;
        end
    endtask

    // One cycle: inputs were set at the preceding negedge. Check outputs
    // 1 time unit later, advance the model, and move on to the next negedge.
    task automatic step();
        ex_t id;
        logic hz, st, match;
        #1;
        if (!rst_n) model_reset();
        id = {a1, a2, a3, d1, d2, d3, opc, dest, wr, ld};
        for (int d = 0; d < 2; d++) begin
            match = (a1 == m_ex[d].dest) || (a2 == m_ex[d].dest) || ({1'b0, a3} == m_ex[d].dest);
            hz = (m_owed[d] == 0) && m_ex[d].ld && m_ex[d].wr && rd && match;
            st = !flush && (hz || m_owed[d] > 0);
            check($sformatf("L%0d ex_payload", lat[d]), 64'(got_ex[d]), 64'(m_ex[d]));
            check($sformatf("L%0d stall_IF", lat[d]), 64'(d == 0 ? x1_stall : x3_stall), 64'(st));
            check($sformatf("L%0d stall_cycles", lat[d]), 64'(d == 0 ? x1_sc : x3_sc), 64'(m_sc[d]));
            if (rst_n && en) begin
                if (flush) begin
                    m_ex[d]   = '0;
                    m_owed[d] = 0;
                end else if (st) begin
                    m_ex[d]   = '0;
                    m_owed[d] = hz ? lat[d] - 1 : m_owed[d] - 1;
                end else begin
                    m_ex[d] = id;
                end
                if (st && m_sc[d] < 65535) m_sc[d]++;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_id(input logic [3:0] s1, input logic [3:0] s2, input logic [2:0] s3,
                          input logic [3:0] dst, input logic w, input logic l, input logic r);
        a1 = s1; a2 = s2; a3 = s3; dest = dst; wr = w; ld = l; rd = r;
        d1 = DW'($urandom); d2 = DW'($urandom); d3 = 8'($urandom); opc = 5'($urandom);
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) begin
            set_id(4'hF, 4'hF, 3'd7, 4'hE, 1'b0, 1'b0, 1'b0);
            step();
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; flush = 1'b0;
        set_id(4'h0, 4'h0, 3'd0, 4'h0, 1'b0, 1'b0, 1'b0);
        model_reset();
        @(negedge clk);
        step();                      // reset state: all zero
        rst_n = 1'b1;

        // Plain capture with 1-cycle latency.
        set_id(4'h1, 4'h2, 3'd3, 4'h5, 1'b1, 1'b0, 1'b1);
        d1 = 16'h003A;
        step();
        nop(2);

        // op2 load-use on r5: 1 stall (L1) / 3 stalls (L3), then capture.
        set_id(4'h0, 4'h0, 3'd0, 4'h5, 1'b1, 1'b1, 1'b0);
        step();
        set_id(4'h1, 4'h5, 3'd2, 4'h6, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step();
        nop(3);

        // op3 load-use on r5.
        set_id(4'h0, 4'h0, 3'd0, 4'h5, 1'b1, 1'b1, 1'b0);
        step();
        set_id(4'h1, 4'h2, 3'd5, 4'h6, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step();
        nop(3);

        // Register 0 dependency is real.
        set_id(4'h3, 4'h3, 3'd3, 4'h0, 1'b1, 1'b1, 1'b0);
        step();
        set_id(4'h0, 4'h9, 3'd1, 4'h7, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step();
        nop(3);

        // Flush on the 2nd stall cycle, then a fresh instruction.
        set_id(4'h0, 4'h0, 3'd0, 4'h5, 1'b1, 1'b1, 1'b0);
        step();
        set_id(4'h5, 4'h2, 3'd1, 4'h6, 1'b1, 1'b0, 1'b1);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        set_id(4'h8, 4'h9, 3'd4, 4'hA, 1'b1, 1'b0, 1'b1);
        step();
        nop(3);

        // en=0 for 4 cycles mid-stall.
        set_id(4'h0, 4'h0, 3'd0, 4'h5, 1'b1, 1'b1, 1'b0);
        step();
        set_id(4'h5, 4'h2, 3'd1, 4'h6, 1'b1, 1'b0, 1'b1);
        step();
        en = 1'b0;
        for (int i = 0; i < 4; i++) step();
        en = 1'b1;
        for (int i = 0; i < 4; i++) step();
        nop(3);

        // No stall: load with rd=0, and non-load with matching address.
        set_id(4'h0, 4'h0, 3'd0, 4'h5, 1'b1, 1'b1, 1'b0);
        step();
        set_id(4'h5, 4'h5, 3'd5, 4'h6, 1'b1, 1'b0, 1'b0);
        step();
        set_id(4'h0, 4'h0, 3'd0, 4'h5, 1'b1, 1'b0, 1'b0);
        step();
        set_id(4'h5, 4'h5, 3'd5, 4'h6, 1'b1, 1'b0, 1'b1);
        step();
        nop(2);

        // Reset in the middle of a stall aborts it.
        set_id(4'h0, 4'h0, 3'd0, 4'h5, 1'b1, 1'b1, 1'b0);
        step();
        set_id(4'h5, 4'h2, 3'd1, 4'h6, 1'b1, 1'b0, 1'b1);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        nop(2);

        // Randomized traffic; narrow address range to provoke dependencies.
        for (int i = 0; i < 3000; i++) begin
            set_id(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
                   4'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
            flush = ($urandom_range(0, 19) == 0);
            en    = ($urandom_range(0, 7) != 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
